// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures decoded operands and control, inserts
// bubbles on flush or load-use hazard, and keeps saturating event counters.
module id_ex_pipe #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [N-1:0]     pc_4,
    input  logic [N-1:0]     pc,
    input  logic [N-1:0]     read_data_1,
    input  logic [N-1:0]     read_data_2,
    input  logic [N-1:0]     imm,
    input  logic [N-1:0]     instruction,
    input  logic             auipc,
    input  logic             reg_write,
    input  logic             branch,
    input  logic             jal,
    input  logic             jalr,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             alu_src,
    input  logic [2:0]       alu_op,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic [N-1:0]     pc_4_o,
    output logic [N-1:0]     pc_o,
    output logic [N-1:0]     read_data_1_o,
    output logic [N-1:0]     read_data_2_o,
    output logic [N-1:0]     imm_o,
    output logic [N-1:0]     instruction_o,
    output logic             auipc_o,
    output logic             reg_write_o,
    output logic             branch_o,
    output logic             jal_o,
    output logic             jalr_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             alu_src_o,
    output logic [2:0]       alu_op_o,
    output logic             valid_o,
    output logic             funct_7,
    output logic [2:0]       funct_3,
    output logic [4:0]       write_register,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic             load_use_stall_o,
    output logic [CNT_W-1:0] bubble_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam logic [N-1:0] NOP_INSTR = N'(32'h0000_0013);

    typedef struct packed {
        logic         valid;
        logic [N-1:0] pc_4;
        logic [N-1:0] pc;
        logic [N-1:0] read_data_1;
        logic [N-1:0] read_data_2;
        logic [N-1:0] imm;
        logic [N-1:0] instruction;
        logic         auipc;
        logic         reg_write;
        logic         branch;
        logic         jal;
        logic         jalr;
        logic         mem_read;
        logic         mem_write;
        logic         mem_to_reg;
        logic         alu_src;
        logic [2:0]   alu_op;
        logic         funct_7;
        logic [2:0]   funct_3;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
    } stage_t;

    stage_t stage_q;
    stage_t capture_d;
    stage_t bubble_d;
    logic   hazard;
    logic   load_bubble;

    always_comb begin
        // NOTE: every field gets a default before conditional overrides so no latch is inferred.
        capture_d             = '0;
        capture_d.valid       = valid_i;
        capture_d.pc_4        = pc_4;
        capture_d.pc          = pc;
        capture_d.read_data_1 = read_data_1;
        capture_d.read_data_2 = read_data_2;
        capture_d.imm         = imm;
        capture_d.instruction = instruction;
        if (valid_i) begin
            capture_d.auipc      = auipc;
            capture_d.reg_write  = reg_write;
            capture_d.branch     = branch;
            capture_d.jal        = jal;
            capture_d.jalr       = jalr;
            capture_d.mem_read   = mem_read;
            capture_d.mem_write  = mem_write;
            capture_d.mem_to_reg = mem_to_reg;
            capture_d.alu_src    = alu_src;
            capture_d.alu_op     = alu_op;
        end
        capture_d.funct_7 = instruction[30];
        capture_d.funct_3 = instruction[14:12];
        capture_d.rd      = instruction[11:7];
        capture_d.rs1     = instruction[19:15];
        capture_d.rs2     = instruction[24:20];

        bubble_d             = '0;
        bubble_d.instruction = NOP_INSTR;
    end

    // Conservative: both source fields are compared whatever the opcode.
    assign hazard = stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0) & valid_i &
                    ((stage_q.rd == instruction[19:15]) | (stage_q.rd == instruction[24:20]));

    assign load_use_stall_o = hazard & ~flush_i & ~hold_i;
    assign load_bubble      = reset | flush_i | (hazard & ~hold_i);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (load_bubble) begin
            stage_q <= bubble_d;
        end else if (!hold_i) begin
            stage_q <= capture_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count_o <= '0;
            flush_count_o  <= '0;
        end else if (flush_i) begin
            if (flush_count_o != '1) flush_count_o <= flush_count_o + CNT_W'(1);
        end else if (!hold_i && hazard) begin
            if (bubble_count_o != '1) bubble_count_o <= bubble_count_o + CNT_W'(1);
        end
    end

    assign valid_o        = stage_q.valid;
    assign pc_4_o         = stage_q.pc_4;
    assign pc_o           = stage_q.pc;
    assign read_data_1_o  = stage_q.read_data_1;
    assign read_data_2_o  = stage_q.read_data_2;
    assign imm_o          = stage_q.imm;
    assign instruction_o  = stage_q.instruction;
    assign auipc_o        = stage_q.auipc;
    assign reg_write_o    = stage_q.reg_write;
    assign branch_o       = stage_q.branch;
    assign jal_o          = stage_q.jal;
    assign jalr_o         = stage_q.jalr;
    assign mem_read_o     = stage_q.mem_read;
    assign mem_write_o    = stage_q.mem_write;
    assign mem_to_reg_o   = stage_q.mem_to_reg;
    assign alu_src_o      = stage_q.alu_src;
    assign alu_op_o       = stage_q.alu_op;
    assign funct_7        = stage_q.funct_7;
    assign funct_3        = stage_q.funct_3;
    assign write_register = stage_q.rd;
    assign rs1_o          = stage_q.rs1;
    assign rs2_o          = stage_q.rs2;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: a cycle-level reference model checked on every
// falling edge, plus literal expectations for reset, capture, hazards, hold, flush, saturation.
module tb_id_ex_pipe;

    localparam int N     = 32;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic valid_i;
    logic [N-1:0] pc_4, pc, read_data_1, read_data_2, imm, instruction;
    logic auipc, reg_write, branch, jal, jalr, mem_read, mem_write, mem_to_reg, alu_src;
    logic [2:0] alu_op;
    logic hold_i, flush_i;
    logic [N-1:0] pc_4_o, pc_o, read_data_1_o, read_data_2_o, imm_o, instruction_o;
    logic auipc_o, reg_write_o, branch_o, jal_o, jalr_o, mem_read_o, mem_write_o;
    logic mem_to_reg_o, alu_src_o;
    logic [2:0] alu_op_o;
    logic valid_o, funct_7;
    logic [2:0] funct_3;
    logic [4:0] write_register, rs1_o, rs2_o;
    logic load_use_stall_o;
    logic [CNT_W-1:0] bubble_count_o, flush_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i),
        .pc_4(pc_4), .pc(pc), .read_data_1(read_data_1), .read_data_2(read_data_2),
        .imm(imm), .instruction(instruction),
        .auipc(auipc), .reg_write(reg_write), .branch(branch), .jal(jal), .jalr(jalr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .hold_i(hold_i), .flush_i(flush_i),
        .pc_4_o(pc_4_o), .pc_o(pc_o), .read_data_1_o(read_data_1_o),
        .read_data_2_o(read_data_2_o), .imm_o(imm_o), .instruction_o(instruction_o),
        .auipc_o(auipc_o), .reg_write_o(reg_write_o), .branch_o(branch_o), .jal_o(jal_o),
        .jalr_o(jalr_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_to_reg_o(mem_to_reg_o), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o),
        .valid_o(valid_o), .funct_7(funct_7), .funct_3(funct_3),
        .write_register(write_register), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .load_use_stall_o(load_use_stall_o),
        .bubble_count_o(bubble_count_o), .flush_count_o(flush_count_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the stage should hold, as plain values.
    typedef struct {
        bit          valid;
        logic [31:0] pc4, pc, rd1, rd2, imm, instr;
        logic [8:0]  ctrl;   // {auipc,reg_write,branch,jal,jalr,mem_read,mem_write,mem_to_reg,alu_src}
        logic [2:0]  alu_op;
    } model_t;

    model_t m;
    int     m_bubbles = 0;
    int     m_flushes = 0;
    bit     model_ok  = 0;

    function automatic model_t bubble_model();
        model_t b;
        b.valid = 0; b.pc4 = 0; b.pc = 0; b.rd1 = 0; b.rd2 = 0; b.imm = 0;
        b.instr = 32'h13; b.ctrl = 0; b.alu_op = 0;
        return b;
    endfunction

    // A load sits in the stage and the incoming real instruction reads its destination.
    function automatic bit model_hazard();
        logic [4:0] dest;
        dest = m.instr[11:7];
        return m.valid && m.ctrl[3] && dest != 0 && valid_i &&
               (dest == instruction[19:15] || dest == instruction[24:20]);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m = bubble_model(); m_bubbles = 0; m_flushes = 0; model_ok = 1;
        end else if (flush_i) begin
            m = bubble_model();
            if (m_flushes < CMAX) m_flushes++;
        end else if (hold_i) begin
            // stage frozen
        end else if (model_hazard()) begin
            m = bubble_model();
            if (m_bubbles < CMAX) m_bubbles++;
        end else begin
            m.valid = valid_i; m.pc4 = pc_4; m.pc = pc; m.rd1 = read_data_1;
            m.rd2 = read_data_2; m.imm = imm; m.instr = instruction;
            m.ctrl = valid_i ? {auipc, reg_write, branch, jal, jalr, mem_read, mem_write,
                                mem_to_reg, alu_src} : 9'd0;
            m.alu_op = valid_i ? alu_op : 3'd0;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("valid_o", 64'(valid_o), 64'(m.valid));
            check("pc_4_o", 64'(pc_4_o), 64'(m.pc4));
            check("pc_o", 64'(pc_o), 64'(m.pc));
            check("read_data_1_o", 64'(read_data_1_o), 64'(m.rd1));
            check("read_data_2_o", 64'(read_data_2_o), 64'(m.rd2));
            check("imm_o", 64'(imm_o), 64'(m.imm));
            check("instruction_o", 64'(instruction_o), 64'(m.instr));
            check("ctrl", 64'({auipc_o, reg_write_o, branch_o, jal_o, jalr_o, mem_read_o,
                               mem_write_o, mem_to_reg_o, alu_src_o}), 64'(m.ctrl));
            check("alu_op_o", 64'(alu_op_o), 64'(m.alu_op));
            check("funct_7", 64'(funct_7), 64'(m.instr[30]));
            check("funct_3", 64'(funct_3), 64'(m.instr[14:12]));
            check("write_register", 64'(write_register), 64'(m.instr[11:7]));
            check("rs1_o", 64'(rs1_o), 64'(m.instr[19:15]));
            check("rs2_o", 64'(rs2_o), 64'(m.instr[24:20]));
            check("stall", 64'(load_use_stall_o), 64'(model_hazard() && !flush_i && !hold_i));
            check("bubble_count_o", 64'(bubble_count_o), 64'(m_bubbles));
            check("flush_count_o", 64'(flush_count_o), 64'(m_flushes));
        end
    end

    localparam logic [31:0] ADD_X10 = 32'h00A5_8533;  // add x10,x11,x10
    localparam logic [31:0] LW_X5   = 32'h0000_A283;  // lw  x5,0(x1)
    localparam logic [31:0] ADD_X6  = 32'h0072_8333;  // add x6,x5,x7
    localparam logic [31:0] LW_X0   = 32'h0000_A003;  // lw  x0,0(x1)
    localparam logic [31:0] ADD_X0S = 32'h0070_0333;  // add x6,x0,x7

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ins,
                         input logic is_load);
        valid_i     = v;
        pc          = p;
        pc_4        = p + 32'd4;
        read_data_1 = p ^ 32'hA5A5_0000;
        read_data_2 = ~p;
        imm         = p << 1;
        instruction = ins;
        mem_read    = is_load;
        mem_to_reg  = is_load;
        alu_src     = is_load;
        reg_write   = 1'b1;
        auipc       = 1'b0;
        branch      = (ins[6:0] == 7'h63);
        jal         = 1'b0;
        jalr        = 1'b0;
        mem_write   = 1'b0;
        alu_op      = ins[14:12];
    endtask

    initial begin
        reset = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
        drive(1'b1, 32'h4444, LW_X5, 1'b1);
        tick(); tick();
        check("rst valid_o", 64'(valid_o), 64'd0);
        check("rst instruction_o", 64'(instruction_o), 64'h13);
        check("rst mem_read_o", 64'(mem_read_o), 64'd0);
        check("rst reg_write_o", 64'(reg_write_o), 64'd0);
        check("rst counters", 64'({bubble_count_o, flush_count_o}), 64'd0);

        reset = 1'b0;
        drive(1'b1, 32'h100, ADD_X10, 1'b0);
        tick();
        check("cap pc_o", 64'(pc_o), 64'h100);
        check("cap write_register", 64'(write_register), 64'd10);
        check("cap rs1_o", 64'(rs1_o), 64'd11);
        check("cap rs2_o", 64'(rs2_o), 64'd10);
        check("cap funct_3", 64'(funct_3), 64'd0);
        check("cap funct_7", 64'(funct_7), 64'd0);

        drive(1'b1, 32'h104, LW_X5, 1'b1);
        tick();
        drive(1'b1, 32'h108, ADD_X6, 1'b0);
        #1 check("lu stall", 64'(load_use_stall_o), 64'd1);
        tick();
        check("lu bubble valid_o", 64'(valid_o), 64'd0);
        check("lu bubble_count", 64'(bubble_count_o), 64'd1);
        check("lu stall cleared", 64'(load_use_stall_o), 64'd0);
        tick();
        check("lu add captured", 64'(instruction_o), 64'(ADD_X6));
        check("lu add valid", 64'(valid_o), 64'd1);

        drive(1'b1, 32'h10C, LW_X0, 1'b1);
        tick();
        drive(1'b1, 32'h110, ADD_X0S, 1'b0);
        #1 check("x0 no stall", 64'(load_use_stall_o), 64'd0);
        tick();
        check("x0 captured", 64'(instruction_o), 64'(ADD_X0S));
        check("x0 no bubble", 64'(bubble_count_o), 64'd1);

        // Hold with a hazard pending: frozen for 3 edges, then the hazard fires.
        drive(1'b1, 32'h114, LW_X5, 1'b1);
        tick();
        drive(1'b1, 32'h118, ADD_X6, 1'b0);
        hold_i = 1'b1;
        #1 check("hold no stall", 64'(load_use_stall_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold frozen instr", 64'(instruction_o), 64'(LW_X5));
            check("hold frozen pc", 64'(pc_o), 64'h114);
            check("hold counters", 64'({bubble_count_o, flush_count_o}), 64'({2'd1, 2'd0}));
        end
        hold_i = 1'b0;
        #1 check("release stall", 64'(load_use_stall_o), 64'd1);
        tick();
        check("release bubble", 64'(valid_o), 64'd0);
        check("release bubble_count", 64'(bubble_count_o), 64'd2);
        tick();
        check("release add", 64'(instruction_o), 64'(ADD_X6));

        hold_i = 1'b1; flush_i = 1'b1;
        tick();
        check("hold+flush valid_o", 64'(valid_o), 64'd0);
        check("hold+flush flush_count", 64'(flush_count_o), 64'd1);
        hold_i = 1'b0; flush_i = 1'b0;

        drive(1'b1, 32'h11C, LW_X5, 1'b1);
        tick();
        drive(1'b1, 32'h120, ADD_X6, 1'b0);
        flush_i = 1'b1;
        #1 check("flush+hazard stall", 64'(load_use_stall_o), 64'd0);
        tick();
        check("flush+hazard bubbles", 64'(bubble_count_o), 64'd2);
        check("flush+hazard flushes", 64'(flush_count_o), 64'd2);
        flush_i = 1'b0;
        tick();

        // Mid-stream reset discards the in-flight instruction.
        drive(1'b1, 32'h200, LW_X5, 1'b1);
        reset = 1'b1;
        tick();
        check("mid rst valid_o", 64'(valid_o), 64'd0);
        check("mid rst counters", 64'({bubble_count_o, flush_count_o}), 64'd0);
        reset = 1'b0;

        flush_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("sat flush_count", 64'(flush_count_o), 64'((i < 3) ? i : 3));
        end
        flush_i = 1'b0;

        // Invalid slot: datapath captured, control forced low.
        drive(1'b0, 32'h300, LW_X5, 1'b1);
        tick();
        check("inv valid_o", 64'(valid_o), 64'd0);
        check("inv pc_o", 64'(pc_o), 64'h300);
        check("inv mem_read_o", 64'(mem_read_o), 64'd0);
        check("inv instruction_o", 64'(instruction_o), 64'(LW_X5));
        drive(1'b1, 32'h304, ADD_X6, 1'b0);
        #1 check("inv no stall", 64'(load_use_stall_o), 64'd0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline register with in-stage hazard handling, sitting between the decode stage (register file, immediate generator, control unit) and the execute stage. It adds the following on top of a plain latch:
- a valid bit;
- downstream hold (stall);
- branch/jump flush;
- load-use hazard detection with automatic bubble insertion;
- rs1/rs2 capture for the forwarding unit;
- saturating bubble and flush counters for performance analysis.

## Interface
Parameters:
- N, 32, datapath width (pc, operands, immediate, instruction); N ≥ 32
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- valid_i  in  1  decode stage presents a real instruction
- pc_4, pc  in  N  PC+4 and PC of decoded instruction
- read_data_1, read_data_2  in  N  register file operands
- imm  in  N  generated immediate
- instruction  in  N  raw instruction (bits 31:0 meaningful)
- auipc, reg_write, branch, jal, jalr, mem_read, mem_write, mem_to_reg, alu_src  in  1 each  control unit outputs
- alu_op  in  3  ALU operation class
- hold_i  in  1  execute/memory side stalled; freeze stage
- flush_i  in  1  taken branch/jump redirect; kill stage contents
- pc_4_o, pc_o, read_data_1_o, read_data_2_o, imm_o, instruction_o  out  N  registered copies
- auipc_o … alu_src_o  out  1 each; alu_op_o  out  3  registered control
- valid_o  out  1  stage holds a real instruction
- funct_7  out  1  instruction[30]
- funct_3  out  3  instruction[14:12]
- write_register  out  5  instruction[11:7]
- rs1_o, rs2_o  out  5  instruction[19:15], instruction[24:20]
- load_use_stall_o  out  1  combinational; IF/ID and PC must hold this cycle
- bubble_count_o, flush_count_o  out  CNT_W  saturating event counters

## Operation
Hazard term (combinational):
- hazard = valid_o & mem_read_o & (write_register ≠ 0) & valid_i & (write_register == instruction[19:15] | write_register == instruction[24:20]).
- Both source fields are compared regardless of opcode (conservative).
- load_use_stall_o = hazard & ~flush_i & ~hold_i.

Per-edge action, evaluated in priority order:
1. **reset**: load the bubble state; both counters to 0.
2. **flush_i**: load the bubble state; flush_count_o += 1. Flush overrides hold_i.
3. **hold_i**: all registers keep their value; counters unchanged.
4. **hazard**: load the bubble state; bubble_count_o += 1. The decode-side instruction is re-presented next cycle because load_use_stall_o = 1.
5. **otherwise (capture)**:
   - all _o registers take their inputs;
   - valid_o = valid_i;
   - fields are sliced from instruction.
   - If valid_i = 0, control outputs are forced to 0 while the datapath still captures.

Bubble state:
- valid_o = 0; all control outputs = 0; alu_op_o = 0;
- pc_4_o, pc_o, read_data_1_o, read_data_2_o, imm_o = 0;
- instruction_o = 32'h00000013 (addi x0,x0,0), zero-extended to N;
- funct_7 = 0, funct_3 = 0, write_register = 0, rs1_o = 0, rs2_o = 0.

Counters: saturate at all-ones and never wrap.

## Timing
- Latency: one clock from inputs to _o outputs.
- No combinational path from data inputs to any registered output.
- load_use_stall_o is valid in the same cycle as the offending instruction at the inputs. It is asserted exactly one cycle per load-use pair, because the bubble clears mem_read_o.
- Reset is sampled only on the rising edge. Asserting reset mid-stream discards the in-flight instruction that edge; load_use_stall_o is 0 while the bubble state is present.
- Simultaneous flush_i and hold_i: the flush wins, and the stage is a bubble next cycle.
- Simultaneous flush_i and hazard:
  - the flush wins and load_use_stall_o = 0;
  - bubble_count_o is unchanged and flush_count_o increments.
- Hold for k cycles: outputs are stable for k cycles. A hazard pending at hold release is evaluated on the first unheld edge.

## Test plan
- **Reset**: assert reset for 2 cycles with arbitrary inputs.
  - Required: valid_o = 0, instruction_o = 0x13, all controls 0, counters 0.
- **Capture**: valid_i = 1, pc = 0x100, instruction = 0x00A58533 (add x10,x11,x10).
  - Required, next edge: pc_o = 0x100, write_register = 10, rs1_o = 11, rs2_o = 10, funct_3 = 0, funct_7 = 0.
- **Load-use**:
  - Stage holds lw x5 (mem_read_o = 1, write_register = 5); input is add x6,x5,x7.
  - Required: load_use_stall_o = 1 that cycle; next edge produces a bubble and bubble_count_o = 1.
  - Following cycle: the add is captured and load_use_stall_o = 0.
- **x0 load**: same as the load-use case but write_register = 0.
  - Required: no stall, no bubble.
- **Hold/flush**:
  - hold_i for 3 cycles: outputs frozen, counters unchanged.
  - hold_i and flush_i together: bubble next edge, flush_count_o = 1.
- **Saturation**: with CNT_W = 2, issue 5 flushes.
  - Required: flush_count_o stops at 3.
